console_pin_ctrl: RTL and testbench
===================================

# console_pin_ctrl

Parametrised pin and event controller between the chip pads and the PPU/synth core of the retro console. It samples a boot configuration while in reset and registers all pad inputs and outputs. It multiplexes PPU pixel data onto the output pins in one of three colour modes, loops RAM data pins back to address pins while the PPU is held in reset, and arbitrates `NUM_EVENTS` maskable event sources into a single request/ack handshake toward the synth's serial transmitter.

## Interface
Parameters:
- `RAM_PINS`, 4: width of the RAM address and data pin buses.
- `IO_BITS`, 2: width of the serial tx/rx pin buses.
- `NUM_EVENTS`, 4: number of event channels (1..8).
- `CFG_BITS`, 4: number of configuration bits sampled from `ui_in` during reset.

Ports (reset is asynchronous, active-high; single clock `clk`):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous active-high reset.
- `ui_in` in 8: dedicated input pads.
- `uio_in` in 8: bidirectional input pads.
- `uo_out` out 8: dedicated output pads, registered.
- `uio_out` out 8: bidirectional output pads, registered.
- `uio_oe` out 8: bidirectional output enables.
- `cfg` out CFG_BITS: captured boot configuration.
- `ppu_ctrl` in 8: PPU control bits (`PPU_CTRL_BIT_*` from `ppu_common.vh`).
- `ppu_reset` in 1: PPU held in reset.
- `addr_pins` in RAM_PINS: PPU address output.
- `data_pins` out RAM_PINS: RAM data toward the PPU.
- `tx_pins` in IO_BITS: serial transmit data from the synth.
- `rx_pins` out IO_BITS: registered serial receive data.
- `rgb_in` in 12: PPU RGB444 pixel.
- `rgb_dith_in` in 6: PPU dithered RGB222 pixel.
- `hsync`, `vsync`, `active`, `pix_phase` in 1 each: PPU timing signals.
- `event_pulse` in NUM_EVENTS: one-cycle event strobes.
- `event_en` in NUM_EVENTS: per-channel enable.
- `tx_request` out 1: at least one event is pending.
- `tx_ack` in 1: one-cycle acknowledge of the presented event.
- `event_id` out $clog2(NUM_EVENTS) (minimum 1): channel currently presented.
- `event_drop` out NUM_EVENTS: sticky overflow flag per channel.
- `drop_clr` in 1: clears all `event_drop` bits.

## Operation
- **Config capture.**
  - `cfg` has no reset value. It loads `ui_in[CFG_BITS-1:0]` on every `clk` edge while `reset` is high and holds after deassertion.
  - `cfg[0]` selects the rx source (1: `ui_in[5:4]`, 0: `uio_in[7:6]`) and enables driving of `uio[7:6]`.
- **Input registers.**
  - `ui_in`, `uio_in` and the selected rx pair are registered once.
  - `data_pins` is `ui_in_reg[RAM_PINS-1:0]` when `PPU_CTRL_BIT_SYNC_DATA` is set, otherwise the raw `ui_in[RAM_PINS-1:0]`.
- **Address loopback.** `uio_out0[RAM_PINS-1:0]` is `data_pins` while `ppu_reset` is high, otherwise `addr_pins`.
- **Colour mode.** `mode` is {`RGB332_OUT`, `DITHER`} from `ppu_ctrl`. Mode encodings are `OUTMODE_RGB444HI`, `OUTMODE_DITH`, `OUTMODE_RGB332`; RGB332 takes priority over DITH.
  - `uo_out0` = {hsync, B0, G0, R0, vsync, B1, G1, R1}.
  - B0/B1, G0/G1, R0/R1 are the colour bits in the order given by the next three items.
  - RGB444HI: bits [2]/[3] of each channel.
  - DITH: `rgb_dith_in` bits.
  - RGB332: same as RGB444HI, plus `uio_out0[6]` = G1 and `uio_out0[7]` = R1.
  - In the other modes `uio_out0[6]` = `active` and `uio_out0[7]` = `pix_phase`.
  - Both `uio_out0[7:6]` bits are ANDed with `cfg[0]`, except `active`, which is never gated.
- **Tx pins.** `uio_out0[RAM_PINS+IO_BITS-1:RAM_PINS]` = `tx_pins`.
- **Output enables.**
  - `uio_oe` = all ones for bits [5:0].
  - `uio_oe[7:6]` = `cfg[0]` replicated, forced 0 while `reset` is high.
- **Event arbiter.**
  - `pending[i]` sets on `event_pulse[i] && event_en[i]`.
  - `pending[i]` clears on an ack of channel i.
  - `pending[i]` clears immediately when `event_en[i]` is low.
- **Event presentation.**
  - `tx_request` = |pending.
  - `event_id` is latched to the lowest pending index whenever no event is being presented or an ack occurs. It stays stable between acks.

## Timing
- **Reset values.** On `reset` all registered outputs go to 0 immediately (async):
  - `uo_out`, `uio_out`, `rx_pins`.
  - `pending`, `tx_request`, `event_id`, `event_drop`.
- **Output latency.** Pad outputs lag internal signals by 1 cycle. Input registers also add 1 cycle.
- **Event latency.** A pulse at cycle n gives `pending` (and `tx_request`) at n+1.
- **Ack handling.**
  - An ack at cycle n clears the presented channel at n+1.
  - The next `event_id` is valid at n+1.
  - An ack while `tx_request` is low is ignored.
- **Simultaneous pulse and ack on the same channel.** The pending bit stays set; this is a new event, not a drop.
- **Drop flag.**
  - A pulse on an already-pending channel without an ack that cycle sets `event_drop[i]`.
  - `drop_clr` wins over a simultaneous set.
- **Mode changes.** A `mode` change takes effect on pins 1 cycle later. There is no glitch masking.
- **Reset mid-handshake.** All pending events are discarded. `tx_request` drops asynchronously.

## Structure
- The `OUTMODE_*` encodings and event-channel indices (`EVENT_VBLANK` = 0, `EVENT_HBLANK` = 1) go in `ppu_common.vh`.
- Sub-module `event_arbiter` (parameter NUM_EVENTS) holds `pending`, `event_drop`, the id latch and the request/ack logic.

## Test plan
- **Config capture.** Hold reset with `ui_in` = 8'h01, release, then change `ui_in` → `cfg` = 4'h1, `uio_oe` = 8'hFF; rx follows `ui_in[5:4]` delayed by 1 cycle.
- **Loopback.** `ppu_reset` = 1, `ui_in[3:0]` = 4'hA → `uio_out[3:0]` = 4'hA two cycles later. With `ppu_reset` = 0 → `uio_out[3:0]` = `addr_pins` delayed 1 cycle.
- **Colour modes.** `rgb_in` = 12'hC84, `rgb_dith_in` = 6'b101101, step through all three modes → `uo_out` = 8'b0_0_1_1_0_1_0_1, then 8'b0_1_1_1_0_0_0_1, then 8'b0_0_1_1_0_1_0_1; in RGB332, `uio_out[7:6]` = 2'b10.
- **Arbiter priority.** Pulse channels 2 and 0 together → `event_id` = 0. Ack → `event_id` = 2 next cycle. Ack → `tx_request` = 0.
- **Overflow.** Pulse channel 1 twice without an ack → `event_drop` = 4'b0010. Pulse together with an ack → no drop. `drop_clr` → `event_drop` = 0.
- **Async reset.** Assert `reset` mid-request, between clock edges → `tx_request` and `uo_out` are 0 before the next edge.

Source files
------------

// File: rtl/console_pin_ctrl_pkg.sv
// Shared PPU control-bit positions, output colour modes and event channel ids
// for the console pin controller.
package console_pin_ctrl_pkg;

    localparam int PPU_CTRL_BIT_SYNC_DATA  = 0;
    localparam int PPU_CTRL_BIT_DITHER     = 1;
    localparam int PPU_CTRL_BIT_RGB332_OUT = 2;

    localparam int EVENT_VBLANK = 0;
    localparam int EVENT_HBLANK = 1;

    typedef enum logic [1:0] {
        OUTMODE_RGB444HI = 2'd0,
        OUTMODE_DITH     = 2'd1,
        OUTMODE_RGB332   = 2'd2
    } outmode_e;

    // X0 is the more significant of the two pin bits per channel.
    typedef struct packed {
        logic b0, g0, r0, b1, g1, r1;
    } colour_t;

    function automatic outmode_e decode_mode(input logic rgb332, input logic dither);
        if (rgb332)      return OUTMODE_RGB332;
        else if (dither) return OUTMODE_DITH;
        else             return OUTMODE_RGB444HI;
    endfunction

    // rgb_in is {R,G,B} nibbles; rgb_dith_in pads are ordered {B0,B1,R0,R1,G1,G0}.
    function automatic colour_t pick_colour(input outmode_e mode, input logic [11:0] rgb,
                                            input logic [5:0] dith);
        colour_t c;
        if (mode == OUTMODE_DITH) begin
            c.b0 = dith[5]; c.b1 = dith[4];
            c.r0 = dith[3]; c.r1 = dith[2];
            c.g1 = dith[1]; c.g0 = dith[0];
        end else begin
            c.r0 = rgb[11]; c.r1 = rgb[10];
            c.g0 = rgb[7];  c.g1 = rgb[6];
            c.b0 = rgb[3];  c.b1 = rgb[2];
        end
        return c;
    endfunction

endpackage

// File: rtl/console_pin_ctrl_event_arbiter.sv
// Maskable event pending bits, sticky drop flags and a lowest-index-first
// request/ack handshake toward the serial transmitter.
module event_arbiter #(
    parameter int NUM_EVENTS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] event_pulse,
    input  logic [NUM_EVENTS-1:0] event_en,
    input  logic                  tx_ack,
    input  logic                  drop_clr,
    output logic                  tx_request,
    output logic [((NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1)-1:0] event_id,
    output logic [NUM_EVENTS-1:0] event_drop
);
    localparam int IDW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

    logic [NUM_EVENTS-1:0] pending_d, pending_q, drop_d, drop_q, set_v, clr_v;
    logic [IDW-1:0]        id_d, id_q, lowest;
    logic                  ack_v;

    always_comb begin
        ack_v     = tx_ack && (|pending_q);
        set_v     = '0;
        clr_v     = '0;
        pending_d = '0;
        drop_d    = '0;
        lowest    = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            set_v[i]     = event_pulse[i] & event_en[i];
            clr_v[i]     = ack_v && (id_q == IDW'(i));
            // A pulse landing with its own ack re-arms the channel instead of dropping.
            pending_d[i] = event_en[i] & (set_v[i] | (pending_q[i] & ~clr_v[i]));
            drop_d[i]    = ~drop_clr & (drop_q[i] | (set_v[i] & pending_q[i] & ~clr_v[i]));
        end
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (pending_d[i]) lowest = IDW'(i);
        end
        // Re-pick only when idle, on ack, or if the presented channel was withdrawn.
        if (!(|pending_q) || ack_v || !pending_d[id_q]) id_d = lowest;
        else                                             id_d = id_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            drop_q    <= '0;
            id_q      <= '0;
        end else begin
            pending_q <= pending_d;
            drop_q    <= drop_d;
            id_q      <= id_d;
        end
    end

    assign tx_request = |pending_q;
    assign event_id   = id_q;
    assign event_drop = drop_q;

endmodule

// File: rtl/console_pin_ctrl.sv
// Pad-side controller: boot config capture, registered pads, PPU colour
// muxing, RAM address loopback and event arbitration toward the synth.
module console_pin_ctrl
    import console_pin_ctrl_pkg::*;
#(
    parameter int RAM_PINS   = 4,
    parameter int IO_BITS    = 2,
    parameter int NUM_EVENTS = 4,
    parameter int CFG_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            ui_in,
    input  logic [7:0]            uio_in,
    output logic [7:0]            uo_out,
    output logic [7:0]            uio_out,
    output logic [7:0]            uio_oe,
    output logic [CFG_BITS-1:0]   cfg,
    input  logic [7:0]            ppu_ctrl,
    input  logic                  ppu_reset,
    input  logic [RAM_PINS-1:0]   addr_pins,
    output logic [RAM_PINS-1:0]   data_pins,
    input  logic [IO_BITS-1:0]    tx_pins,
    output logic [IO_BITS-1:0]    rx_pins,
    input  logic [11:0]           rgb_in,
    input  logic [5:0]            rgb_dith_in,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic                  active,
    input  logic                  pix_phase,
    input  logic [NUM_EVENTS-1:0] event_pulse,
    input  logic [NUM_EVENTS-1:0] event_en,
    output logic                  tx_request,
    input  logic                  tx_ack,
    output logic [((NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1)-1:0] event_id,
    output logic [NUM_EVENTS-1:0] event_drop,
    input  logic                  drop_clr
);
    logic [CFG_BITS-1:0] cfg_d, cfg_q;
    logic [7:0]          ui_in_q, uio_in_q, uo_d, uo_q, uio_d, uio_q;
    logic [IO_BITS-1:0]  rx_d, rx_q;
    outmode_e            mode;
    colour_t             col;
    logic                unused_inputs;

    // Config is a plain flop loaded through the mux so it keeps no reset value.
    always_comb cfg_d = reset ? ui_in[CFG_BITS-1:0] : cfg_q;
    always_ff @(posedge clk) cfg_q <= cfg_d;

    assign rx_d = cfg_q[0] ? ui_in[4 +: IO_BITS] : uio_in[8-IO_BITS +: IO_BITS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ui_in_q  <= '0;
            uio_in_q <= '0;
            rx_q     <= '0;
            uo_q     <= '0;
            uio_q    <= '0;
        end else begin
            ui_in_q  <= ui_in;
            uio_in_q <= uio_in;
            rx_q     <= rx_d;
            uo_q     <= uo_d;
            uio_q    <= uio_d;
        end
    end

    assign data_pins = ppu_ctrl[PPU_CTRL_BIT_SYNC_DATA] ? ui_in_q[RAM_PINS-1:0]
                                                        : ui_in[RAM_PINS-1:0];

    assign mode = decode_mode(ppu_ctrl[PPU_CTRL_BIT_RGB332_OUT], ppu_ctrl[PPU_CTRL_BIT_DITHER]);
    assign col  = pick_colour(mode, rgb_in, rgb_dith_in);
    assign uo_d = {hsync, col.b0, col.g0, col.r0, vsync, col.b1, col.g1, col.r1};

    always_comb begin
        uio_d                      = '0;
        uio_d[RAM_PINS-1:0]        = ppu_reset ? data_pins : addr_pins;
        uio_d[RAM_PINS +: IO_BITS] = tx_pins;
        if (mode == OUTMODE_RGB332) begin
            uio_d[6] = col.g1 & cfg_q[0];
            uio_d[7] = col.r1 & cfg_q[0];
        end else begin
            uio_d[6] = active;
            uio_d[7] = pix_phase & cfg_q[0];
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = uio_q;
    assign uio_oe  = {{2{cfg_q[0] & ~reset}}, 6'h3F};
    assign rx_pins = rx_q;
    assign cfg     = cfg_q;

    event_arbiter #(.NUM_EVENTS(NUM_EVENTS)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .event_pulse (event_pulse),
        .event_en    (event_en),
        .tx_ack      (tx_ack),
        .drop_clr    (drop_clr),
        .tx_request  (tx_request),
        .event_id    (event_id),
        .event_drop  (event_drop)
    );

    assign unused_inputs = ^{ppu_ctrl, ui_in_q, uio_in_q, uio_in};

endmodule

// File: tb/tb_console_pin_ctrl.sv
// Randomised and directed checks of console_pin_ctrl against a cycle-level
// behavioural model of the pad, colour and event rules.
module tb_console_pin_ctrl;
    localparam int NE = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic [7:0]  ui_in = '0, uio_in = '0, ppu_ctrl = '0;
    logic [7:0]  uo_out, uio_out, uio_oe;
    logic [3:0]  cfg, data_pins, addr_pins = '0;
    logic        ppu_reset = 1'b0;
    logic [1:0]  tx_pins = '0, rx_pins, event_id;
    logic [11:0] rgb_in = '0;
    logic [5:0]  rgb_dith_in = '0;
    logic        hsync = 0, vsync = 0, active = 0, pix_phase = 0;
    logic [NE-1:0] event_pulse = '0, event_en = '0, event_drop;
    logic        tx_request, tx_ack = 1'b0, drop_clr = 1'b0;

    int errs = 0, checks = 0;

    // model state
    logic [3:0] m_cfg;
    logic [7:0] m_uiq, m_uo, m_uio;
    logic [1:0] m_rx;
    bit         m_pend[NE];
    bit         m_drop[NE];
    int         m_id;

    always #5 clk = ~clk;

    console_pin_ctrl dut (
        .clk(clk), .reset(reset), .ui_in(ui_in), .uio_in(uio_in), .uo_out(uo_out),
        .uio_out(uio_out), .uio_oe(uio_oe), .cfg(cfg), .ppu_ctrl(ppu_ctrl),
        .ppu_reset(ppu_reset), .addr_pins(addr_pins), .data_pins(data_pins),
        .tx_pins(tx_pins), .rx_pins(rx_pins), .rgb_in(rgb_in), .rgb_dith_in(rgb_dith_in),
        .hsync(hsync), .vsync(vsync), .active(active), .pix_phase(pix_phase),
        .event_pulse(event_pulse), .event_en(event_en), .tx_request(tx_request),
        .tx_ack(tx_ack), .event_id(event_id), .event_drop(event_drop), .drop_clr(drop_clr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        m_uiq = '0; m_uo = '0; m_uio = '0; m_rx = '0; m_id = 0;
        for (int i = 0; i < NE; i++) begin m_pend[i] = 0; m_drop[i] = 0; end
    endtask

    function automatic logic [NE-1:0] pack(input bit a[NE]);
        logic [NE-1:0] v = '0;
        for (int i = 0; i < NE; i++) v[i] = a[i];
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int r, g, b, mode;
        bit r0, r1, g0, g1, b0, b1, busy, ack, withdrawn;
        bit np[NE];
        logic [3:0] data;
        if (reset) begin
            m_cfg = ui_in[3:0];
            model_clear();
            return;
        end
        data = ppu_ctrl[0] ? m_uiq[3:0] : ui_in[3:0];
        mode = ppu_ctrl[2] ? 2 : (ppu_ctrl[1] ? 1 : 0);
        r = int'(rgb_in[11:8]); g = int'(rgb_in[7:4]); b = int'(rgb_in[3:0]);
        if (mode == 1) begin
            b0 = rgb_dith_in[5]; b1 = rgb_dith_in[4]; r0 = rgb_dith_in[3];
            r1 = rgb_dith_in[2]; g1 = rgb_dith_in[1]; g0 = rgb_dith_in[0];
        end else begin
            r0 = bit'((r >> 3) & 1); r1 = bit'((r >> 2) & 1);
            g0 = bit'((g >> 3) & 1); g1 = bit'((g >> 2) & 1);
            b0 = bit'((b >> 3) & 1); b1 = bit'((b >> 2) & 1);
        end
        m_uo  = {hsync, b0, g0, r0, vsync, b1, g1, r1};
        m_uio = {(mode == 2 ? r1 : pix_phase) & m_cfg[0],
                 (mode == 2 ? g1 & m_cfg[0] : active),
                 tx_pins, (ppu_reset ? data : addr_pins)};
        m_rx  = m_cfg[0] ? ui_in[5:4] : uio_in[7:6];
        m_uiq = ui_in;
        busy = 0;
        for (int i = 0; i < NE; i++) busy |= m_pend[i];
        ack = tx_ack && busy;
        for (int i = 0; i < NE; i++) begin
            bit fire, acked;
            fire  = event_pulse[i] && event_en[i];
            acked = ack && (m_id == i);
            np[i] = event_en[i] && (fire || (m_pend[i] && !acked));
            if (drop_clr) m_drop[i] = 0;
            else if (fire && m_pend[i] && !acked) m_drop[i] = 1;
        end
        // keep the presented channel until it is acked, withdrawn or nothing was shown
        withdrawn = !np[m_id];
        if (!busy || ack || withdrawn) begin
            m_id = 0;
            for (int i = NE - 1; i >= 0; i--) if (np[i]) m_id = i;
        end
        m_pend = np;
    endtask

    task automatic check_all();
        bit any;
        any = 0;
        for (int i = 0; i < NE; i++) any |= m_pend[i];
        chk("uo_out", uo_out, m_uo);
        chk("uio_out", uio_out, m_uio);
        chk("rx_pins", rx_pins, m_rx);
        chk("cfg", cfg, m_cfg);
        chk("uio_oe", uio_oe, {{2{m_cfg[0] & ~reset}}, 6'h3F});
        chk("data_pins", data_pins, ppu_ctrl[0] ? m_uiq[3:0] : ui_in[3:0]);
        chk("tx_request", tx_request, any);
        chk("event_id", event_id, m_id);
        chk("event_drop", event_drop, pack(m_drop));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        // config capture
        reset = 1; ui_in = 8'h01;
        step(); step();
        chk("cfg_boot", cfg, 4'h1);
        reset = 0; ui_in = 8'h20;
        step();
        chk("rx_from_ui", rx_pins, 2'b10);
        chk("oe_cfg1", uio_oe, 8'hFF);
        ui_in = 8'h10; step();
        chk("rx_follow", rx_pins, 2'b01);
        ui_in = 8'hFE; step();
        chk("cfg_hold", cfg, 4'h1);

        // loopback
        ppu_ctrl = 8'h01; ppu_reset = 1; ui_in = 8'h0A;
        step(); step();
        chk("loopback", uio_out[3:0], 4'hA);
        ppu_reset = 0; addr_pins = 4'h5;
        step();
        chk("addr_out", uio_out[3:0], 4'h5);

        // colour modes
        rgb_in = 12'hC84; rgb_dith_in = 6'b101101; hsync = 0; vsync = 0;
        ppu_ctrl = 8'h00; step();
        chk("rgb444", uo_out, 8'b0011_0101);
        ppu_ctrl = 8'h02; step();
        chk("dith", uo_out, 8'b0111_0001);
        ppu_ctrl = 8'h04; step();
        chk("rgb332", uo_out, 8'b0011_0101);
        chk("rgb332_uio", uio_out[7:6], 2'b10);

        // arbiter priority
        event_en = 4'hF; event_pulse = 4'b0101; step();
        chk("prio_id0", event_id, 2'd0);
        event_pulse = 4'b0000; tx_ack = 1; step();
        chk("prio_id2", event_id, 2'd2);
        chk("prio_req", tx_request, 1'b1);
        step();
        chk("prio_done", tx_request, 1'b0);
        tx_ack = 0;

        // overflow
        event_pulse = 4'b0010; step(); step();
        chk("drop_set", event_drop, 4'b0010);
        event_pulse = 4'b0000; drop_clr = 1; step();
        chk("drop_clr", event_drop, 4'b0000);
        drop_clr = 0; event_pulse = 4'b0010; tx_ack = 1; step();
        chk("ack_nodrop", event_drop, 4'b0000);
        chk("ack_rearm", tx_request, 1'b1);
        event_pulse = 4'b0000; step();
        tx_ack = 0;

        // async reset mid-request
        hsync = 1; event_pulse = 4'b0001; step();
        event_pulse = 4'b0000;
        chk("req_before_rst", tx_request, 1'b1);
        #2 reset = 1;
        #1;
        chk("rst_req", tx_request, 1'b0);
        chk("rst_uo", uo_out, 8'h00);
        model_clear();
        step();
        reset = 0;

        // randomised traffic
        for (int n = 0; n < 600; n++) begin
            ui_in       = 8'($urandom);
            uio_in      = 8'($urandom);
            ppu_ctrl    = 8'($urandom);
            ppu_reset   = 1'($urandom);
            addr_pins   = 4'($urandom);
            tx_pins     = 2'($urandom);
            rgb_in      = 12'($urandom);
            rgb_dith_in = 6'($urandom);
            {hsync, vsync, active, pix_phase} = 4'($urandom);
            event_pulse = 4'($urandom) & 4'($urandom);
            event_en    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            tx_ack      = 1'($urandom);
            drop_clr    = ($urandom_range(0, 15) == 0);
            reset       = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
